// File: rtl/goe_hit_serializer_if.sv
// rtl/goe_hit_serializer_if.sv - frame capture and index stream signals for goe_hit_serializer
interface goe_hit_serializer_if;
  logic         frame_valid;
  logic         frame_ready;
  logic [255:0] hit_map;
  logic [85:0]  goe_sum;
  logic         out_valid;
  logic         out_ready;
  logic [7:0]   out_idx;
  logic         out_last;

  modport slave (
    input  frame_valid, hit_map, goe_sum, out_ready,
    output frame_ready, out_valid, out_idx, out_last
  );

  modport master (
    output frame_valid, hit_map, goe_sum, out_ready,
    input  frame_ready, out_valid, out_idx, out_last
  );
endinterface

// File: rtl/goe_hit_serializer.sv
// rtl/goe_hit_serializer.sv - emits ascending hit-pixel indices, skipping groups the summary marks empty
// Optional capture-time summary consistency check: define GOE_SUM_CHECK_EN.
module goe_hit_serializer #(
  parameter int MAX_HITS = 64
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  goe_hit_serializer_if.slave   s_bus,
  output logic                  o_done,
  output logic [8:0]            o_hit_count,
  output logic                  o_overflow,
  output logic                  o_mismatch
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SCAN   = 2'd1;
  localparam logic [1:0] ST_FINISH = 2'd2;

  logic [1:0]   r_state;
  logic [255:0] r_w;
  logic [42:0]  r_occ;
  logic [8:0]   r_cnt;
  logic         r_overflow;
  logic         r_mismatch;

  logic [255:0] w_occ_exp;
  logic [42:0]  w_gs_even;
  logic [257:0] w_wpad;
  logic [5:0]   w_g;
  logic         w_occ_any;
  logic [5:0]   w_grp;
  logic [2:0]   w_b;
  logic         w_grp_any;
  logic [7:0]   w_idx;
  logic [255:0] w_onehot;
  logic         w_rem_any;
  logic         w_at_max;
  logic         w_valid;
  logic         w_last;
  logic         w_hs;
  logic         w_grp_clr;
  logic         w_cap_mis;

  genvar gp;
  generate
    for (gp = 0; gp < 256; gp++) begin : g_occ_exp
      assign w_occ_exp[gp] = r_occ[gp / 6];
    end
    for (gp = 0; gp < 43; gp++) begin : g_gs_even
      assign w_gs_even[gp] = s_bus.goe_sum[2 * gp];
    end
  endgenerate

  always_comb begin
    w_g       = 6'd0;
    w_occ_any = 1'b0;
    for (int i = 42; i >= 0; i--) begin
      if (r_occ[i]) begin
        w_g       = 6'(i);
        w_occ_any = 1'b1;
      end
    end
  end

  // Padding keeps the 6-wide select of the short last group in range.
  assign w_wpad = {2'b00, r_w};
  assign w_grp  = w_wpad[{3'b000, w_g} * 9'd6 +: 6];

  always_comb begin
    w_b       = 3'd0;
    w_grp_any = 1'b0;
    for (int i = 5; i >= 0; i--) begin
      if (w_grp[i]) begin
        w_b       = 3'(i);
        w_grp_any = 1'b1;
      end
    end
  end

  assign w_idx     = 8'({3'b000, w_g} * 9'd6) + {5'b00000, w_b};
  assign w_onehot  = 256'(1) << w_idx;
  assign w_rem_any = |(r_w & w_occ_exp & ~w_onehot);
  assign w_at_max  = (r_cnt + 9'd1) == 9'(MAX_HITS);
  assign w_valid   = (r_state == ST_SCAN) & w_occ_any & w_grp_any;
  assign w_last    = w_valid & (~w_rem_any | w_at_max);
  assign w_hs      = w_valid & s_bus.out_ready;
  assign w_grp_clr = (w_grp & ~(6'd1 << w_b)) == 6'd0;

`ifdef GOE_SUM_CHECK_EN
  logic [257:0] w_hpad;
  logic [5:0]   w_cgrp;
  assign w_hpad = {2'b00, s_bus.hit_map};

  always_comb begin
    w_cap_mis = 1'b0;
    w_cgrp    = 6'd0;
    for (int g = 0; g < 43; g++) begin
      w_cgrp = w_hpad[g * 6 +: 6];
      if (((w_cgrp != 6'd0) != s_bus.goe_sum[2 * g]) ||
          (($countones(w_cgrp) >= 2) != s_bus.goe_sum[2 * g + 1]))
        w_cap_mis = 1'b1;
    end
  end
`else
  assign w_cap_mis = 1'b0;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_w        <= '0;
      r_occ      <= '0;
      r_cnt      <= '0;
      r_overflow <= 1'b0;
      r_mismatch <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (s_bus.frame_valid) begin
            r_w        <= s_bus.hit_map;
            r_occ      <= w_gs_even;
            r_cnt      <= '0;
            r_overflow <= 1'b0;
            r_mismatch <= w_cap_mis;
            r_state    <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (!w_occ_any) begin
            r_state <= ST_FINISH;
          end else if (!w_grp_any) begin
            r_occ[w_g] <= 1'b0;
            r_mismatch <= 1'b1;
          end else if (w_hs) begin
            r_w[w_idx] <= 1'b0;
            r_cnt      <= r_cnt + 9'd1;
            if (w_grp_clr)
              r_occ[w_g] <= 1'b0;
            if (w_at_max && w_rem_any)
              r_overflow <= 1'b1;
            if (w_last)
              r_state <= ST_FINISH;
          end
        end
        ST_FINISH: r_state <= ST_IDLE;
        default:   r_state <= ST_IDLE;
      endcase
    end
  end

  assign s_bus.frame_ready = (r_state == ST_IDLE);
  assign s_bus.out_valid   = w_valid;
  assign s_bus.out_idx     = w_valid ? w_idx : 8'd0;
  assign s_bus.out_last    = w_last;
  assign o_done            = (r_state == ST_FINISH);
  assign o_hit_count       = r_cnt;
  assign o_overflow        = r_overflow;
  assign o_mismatch        = r_mismatch;

endmodule

// File: doc/goe_hit_serializer.md
# goe_hit_serializer

Sequential readout companion to the stage-0 greater-or-equal summary tree in the MAROC discriminator path. It captures one 256-pixel hit map together with its 86-bit stage-0 summary. It then emits the index of every hit pixel, in ascending order, over a valid/ready stream, using the summary's per-group occupancy bits to skip empty 6-pixel groups. It sits after the trigger decision: the summary tree says "enough pixels fired", and this block says which ones, feeding the event packetizer.

## Interface
- `MAX_HITS`, default 64: maximum indices emitted per frame (1..256); excess hits are dropped and flagged.
- `clk` in 1: single clock, all logic on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `frame_valid` in 1: `hit_map`/`goe_sum` present a frame.
- `frame_ready` out 1: block idle, accepts a frame.
- `hit_map` in 256: pixel hit bits; pixel p = bit p.
- `goe_sum` in 86: stage-0 summary; group g (g=0..42) covers pixels 6g..6g+5 (group 42 = pixels 252..255, upper two bits zero); `goe_sum[2g]` = group has ≥1 hit, `goe_sum[2g+1]` = group has ≥2 hits.
- `out_valid` out 1: `out_idx` valid.
- `out_ready` in 1: downstream accepts index.
- `out_idx` out 8: pixel index.
- `out_last` out 1: qualifies final index of frame.
- `done` out 1: one-cycle pulse, frame finished.
- `hit_count` out 9: indices emitted this frame; valid with `done`, held until next capture.
- `overflow` out 1: frame had more than `MAX_HITS` hits; valid with `done`, held.
- `mismatch` out 1: summary inconsistent with `hit_map`; valid with `done`, held.

## Operation
- States: IDLE, SCAN, FINISH. `frame_ready` = (state==IDLE).
- IDLE: on `frame_valid & frame_ready`, register `hit_map` into the working map W and the even bits of `goe_sum` into occupancy mask OCC[42:0]. Clear the counter, `overflow` and `mismatch`. Go to SCAN.
- SCAN, each cycle: G = lowest set bit of OCC; B = lowest set bit of W[6G+5:6G]; candidate index = 6G+B (8-bit, max 255).
- If OCC[G] is set but the group bits of W are zero: clear OCC[G], set `mismatch`, emit nothing that cycle.
- On handshake (`out_valid & out_ready`): clear W bit, increment the counter, and clear OCC[G] if the group is now empty.
- `out_last` = 1 when the presented index is the last set bit of W under OCC, or when counter+1 == `MAX_HITS`.
- Leave SCAN for FINISH when OCC==0 with no index presented, or when a `out_last` handshake completes.
- Counter reaches `MAX_HITS` while hits remain: set `overflow`; remaining bits are discarded.
- Hits in groups whose OCC bit is 0 are never emitted (summary trusted for skipping).
- FINISH: pulse `done` for one cycle, drive `hit_count`, return to IDLE.
- `out_valid` held and `out_idx`/`out_last` stable while `out_ready`=0.
- `frame_valid` ignored outside IDLE.

## Timing
- Reset values: state IDLE, `frame_ready`=1, `out_valid`=0, `out_idx`=0, `out_last`=0, `done`=0, `hit_count`=0, `overflow`=0, `mismatch`=0.
- Capture at edge N: first `out_valid` in cycle N+1.
- Throughput is one index per cycle with `out_ready` held high; each mismatch group costs one bubble cycle.
- Last handshake at edge M: `done`=1 in cycle M+1, `frame_ready`=1 in cycle M+2.
- Empty frame (OCC==0), captured at edge N: `done` in cycle N+2 with `hit_count`=0; no `out_valid`.
- `rst` mid-frame: immediate abort to reset values; no `done` is issued.

## Configuration
- `GOE_SUM_CHECK_EN` defined: at capture, each group's popcount is compared against both summary bits, including the ≥2 bit. Any disagreement sets `mismatch`. Groups with hits but OCC=0 are still skipped.
- Undefined: capture-time check removed. `mismatch` is set only by the SCAN empty-group case above.

## Test plan
- `hit_map` bits {3,7,200,255}, consistent summary, `out_ready`=1:
  - Indices 3,7,200,255 appear in four consecutive cycles starting N+1.
  - `out_last` is high only on 255.
  - `done` occurs with `hit_count`=4, `overflow`=0, `mismatch`=0.
- All-zero frame -> no `out_valid`; `done` in cycle N+2, `hit_count`=0.
- All 256 bits set, `MAX_HITS`=64:
  - Indices 0..63 are emitted, with `out_last` on 63.
  - `done` occurs with `hit_count`=64 and `overflow`=1.
- Hits {10,11}, `out_ready` toggled 1,0,0,1 -> `out_idx`=11 is held stable through the stall; exactly two handshakes occur.
- `goe_sum[2*5]`=1 but pixels 30..35 zero, plus hit 40 -> one bubble, then index 40 is emitted; `mismatch`=1. With `GOE_SUM_CHECK_EN`, the case of 2 hits with `goe_sum[2g+1]`=0 also sets `mismatch`.
- `rst` asserted mid-SCAN after 2 of 5 indices -> all outputs at reset values next cycle and no `done`; a new frame is then processed normally.
